// File: rtl/mp_add_seq.sv
// mp_add_seq: streams WIDTH-bit operand word pairs through an external adder, least
// significant word first. It chains the carry between words and registers one result word per accepted word.
//
// state | meaning
// FIRST | next accepted word starts an operand; adder cin comes from in_cin
// MID   | continuation word; adder cin comes from the stored carry
module mp_add_seq #(
    parameter int WIDTH  = 32,
    parameter int SWIDTH = WIDTH + 1,
    parameter int NWORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_last,
    input  logic              in_cin,
    output logic              add_cin,
    output logic [WIDTH-1:0]  add_x,
    output logic [WIDTH-1:0]  add_y,
    input  logic [SWIDTH-1:0] add_sm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_word,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_zero,
    output logic              out_trunc
);

    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             zacc_q;

    logic             accept;
    logic             terminal;
    logic             zacc_nxt;
    logic             sum_cout;
    logic [WIDTH-1:0] sum_word;

    // Single output register: a new word may enter whenever the held one leaves.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign add_x   = in_a;
    assign add_y   = in_b;
    assign add_cin = (state == FIRST) ? in_cin : carry_q;

    assign sum_word = add_sm[WIDTH-1:0];
    assign sum_cout = add_sm[WIDTH];
    assign terminal = in_last || (cnt == LAST_CNT);
    assign zacc_nxt = ((state == FIRST) ? 1'b1 : zacc_q) && (sum_word == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FIRST;
            cnt       <= '0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            carry_q   <= sum_cout;
            zacc_q    <= zacc_nxt;
            cnt       <= terminal ? '0 : cnt + CW'(1);
            state     <= terminal ? FIRST : MID;
            out_valid <= 1'b1;
            out_word  <= sum_word;
            out_last  <= terminal;
            out_carry <= terminal && sum_cout;
            out_zero  <= terminal && zacc_nxt && !sum_cout;
            out_trunc <= terminal && !in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed stimulus for mp_add_seq with a behavioural adder and a
// scoreboard of expected result words checked as they leave the DUT.
module tb_mp_add_seq;

    localparam int WIDTH  = 32;
    localparam int SWIDTH = WIDTH + 1;
    localparam int NWORDS = 4;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             last;
        logic             carry;
        logic             zero;
        logic             trunc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_last;
    logic              in_cin;
    logic              add_cin;
    logic [WIDTH-1:0]  add_x;
    logic [WIDTH-1:0]  add_y;
    logic [SWIDTH-1:0] add_sm;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_word;
    logic              out_last;
    logic              out_carry;
    logic              out_zero;
    logic              out_trunc;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state for the operand stream
    logic m_first = 1'b1;
    logic m_carry = 1'b0;
    logic m_zacc  = 1'b0;
    int   m_cnt   = 0;

    always #5 clk = ~clk;

    assign add_sm = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    mp_add_seq #(.WIDTH(WIDTH), .SWIDTH(SWIDTH), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .in_cin    (in_cin),
        .add_cin   (add_cin),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_sm    (add_sm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_trunc (out_trunc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_carry = 1'b0;
        m_zacc  = 1'b0;
        m_cnt   = 0;
    endtask

    // Present one word pair, wait for acceptance, and record the expected result.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic last, input logic cin);
        bit                ok = 0;
        logic              c;
        logic              term;
        logic              z;
        logic [WIDTH:0]    s;
        exp_t              e;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_cin   = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        end else begin
            c    = m_first ? cin : m_carry;
            s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
            term = last || (m_cnt == NWORDS - 1);
            z    = (m_first ? 1'b1 : m_zacc) && (s[WIDTH-1:0] == '0);
            e.word  = s[WIDTH-1:0];
            e.last  = term;
            e.carry = term && s[WIDTH];
            e.zero  = term && z && !s[WIDTH];
            e.trunc = term && !last;
            sb.push_back(e);
            m_carry = s[WIDTH];
            m_zacc  = z;
            m_cnt   = term ? 0 : m_cnt + 1;
            m_first = term;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare each word as it is handed downstream
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            got = {out_word, out_last, out_carry, out_zero, out_trunc};
            if (sb.size() == 0) begin
                chk("unexpected_out", {28'd0, got}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_word_fields", {28'd0, got}, {28'd0, e});
            end
        end
    end

    initial begin
        int waited;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        in_cin    = 1'b1;
        out_ready = 1'b1;

        // Reset state, checked while reset is held
        #3;
        chk("rst_out", {27'd0, out_valid, out_word, out_last, out_carry, out_zero, out_trunc}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_add_cin_1", {63'd0, add_cin}, 64'd1);
        in_cin = 1'b0;
        #1;
        chk("rst_add_cin_0", {63'd0, add_cin}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word with overflow
        send(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        @(negedge clk);
        chk("single_ovf", {out_word, 28'd0, out_last, out_carry, out_zero, out_trunc},
            {32'h0, 28'd0, 4'b1100});
        @(posedge clk);
        #1;

        // Two-word carry chain
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h1, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("chain_last_word", {32'd0, out_word}, 64'h2);
        @(posedge clk);
        #1;

        // Zero result, then the same with carry-in set
        send(32'h0, 32'h0, 1'b0, 1'b0);
        send(32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("zero_flag", {63'd0, out_zero}, 64'd1);
        @(posedge clk);
        #1;
        send(32'h0, 32'h0, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure mid-stream of a 4-word operand
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_a      = 32'h5;
        in_b      = 32'h6;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_word", {31'd0, out_valid, out_word}, {31'd0, 1'b1, 32'h2});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h5, 32'h6, 1'b0, 1'b0);
        send(32'h1, 32'h2, 1'b1, 1'b0);

        // Truncation after NWORDS words, then a fresh operand using in_cin
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b0, 1'b1);
        send(32'h7, 32'h8, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        chk("trunc_flags", {60'd0, out_last, out_carry, out_zero, out_trunc}, 64'hD);
        @(posedge clk);
        #1;
        send(32'h2, 32'h3, 1'b1, 1'b1);

        // Reset mid-operand with a pending carry
        send(32'h1, 32'h2, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        model_reset();
        in_cin = 1'b0;
        @(negedge clk);
        chk("midrst_out", {27'd0, out_valid, out_word, out_last, out_carry, out_zero, out_trunc}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'd10, 32'd20, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_cin", {32'd0, out_word}, 64'd30);
        @(posedge clk);
        #1;

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
